// File: rtl/spi_master_gen.sv
// Full-duplex SPI master: DATA_W-bit words, all four CPOL/CPHA modes, runtime
// half-period divide, LSB/MSB-first order and chip select optionally held between words.
module spi_master_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              ready,
  output logic              done,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              hold_cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);
  localparam int EC_W = $clog2(2*DATA_W+1);
  localparam logic [EC_W-1:0] LAST_EDGE  = EC_W'(2*DATA_W);
  localparam logic [EC_W-1:0] FIRST_EDGE = EC_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t state_reg, state_next;

  logic [DIV_W-1:0]  div_reg, cnt_reg;
  logic [EC_W-1:0]   edge_reg, edge_num;
  logic [DATA_W-1:0] tx_reg, rx_reg, rx_next, data_out_reg;
  logic              cpol_reg, cpha_reg, lsb_reg, hold_reg;
  logic              sclk_reg, cs_n_reg, done_reg, samp_pend_reg;
  logic              tick, edge_now, shift_now, samp_now, finish;

  always_comb begin
    state_next = state_reg;
    tick       = (state_reg != IDLE) && (cnt_reg == div_reg);
    edge_num   = edge_reg + 1'b1;
    edge_now   = (state_reg == XFER) && tick && (edge_reg != LAST_EDGE);
    shift_now  = 1'b0;
    samp_now   = 1'b0;
    if (edge_now) begin
      // Odd edges are leading; the first shift of cpha=1 and the last of cpha=0 are dropped.
      if (cpha_reg) shift_now = edge_num[0] && (edge_num != FIRST_EDGE);
      else          shift_now = !edge_num[0] && (edge_num != LAST_EDGE);
      samp_now = edge_num[0] ^ cpha_reg;
    end

    unique case (state_reg)
      IDLE:  if (go) state_next = cs_n_reg ? SETUP : XFER;
      SETUP: if (tick) state_next = XFER;
      XFER: begin
        if (tick) begin
          // With hold_cs the closing half-period is spent in XFER and HOLD is bypassed.
          if (edge_reg == LAST_EDGE)                      state_next = IDLE;
          else if ((edge_num == LAST_EDGE) && !hold_reg)  state_next = HOLD;
        end
      end
      HOLD:  if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    finish = (state_reg != IDLE) && (state_next == IDLE);

    // miso is captured one cycle after the sampling edge becomes visible on sclk.
    rx_next = rx_reg;
    if (samp_pend_reg)
      rx_next = lsb_reg ? {miso, rx_reg[DATA_W-1:1]} : {rx_reg[DATA_W-2:0], miso};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg       <= '0;
      cnt_reg       <= '0;
      edge_reg      <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      data_out_reg  <= '0;
      cpol_reg      <= 1'b0;
      cpha_reg      <= 1'b0;
      lsb_reg       <= 1'b0;
      hold_reg      <= 1'b0;
      sclk_reg      <= 1'b0;
      cs_n_reg      <= 1'b1;
      done_reg      <= 1'b0;
      samp_pend_reg <= 1'b0;
    end else begin
      done_reg      <= finish;
      samp_pend_reg <= samp_now;
      rx_reg        <= rx_next;
      if (state_reg == IDLE) begin
        sclk_reg <= cpol;
        if (go) begin
          tx_reg   <= data_in;
          div_reg  <= clk_div;
          cpol_reg <= cpol;
          cpha_reg <= cpha;
          lsb_reg  <= lsb_first;
          hold_reg <= hold_cs;
          cnt_reg  <= '0;
          edge_reg <= '0;
          cs_n_reg <= 1'b0;
        end
      end else begin
        cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        if (edge_now) begin
          edge_reg <= edge_num;
          sclk_reg <= ~sclk_reg;
        end
        if (shift_now) tx_reg <= lsb_reg ? (tx_reg >> 1) : (tx_reg << 1);
        if (finish) begin
          cs_n_reg     <= ~hold_reg;
          data_out_reg <= rx_next;
        end
      end
    end
  end

  assign ready    = (state_reg == IDLE);
  assign done     = done_reg;
  assign data_out = data_out_reg;
  assign sclk     = sclk_reg;
  assign cs_n     = cs_n_reg;
  assign mosi     = lsb_reg ? tx_reg[0] : tx_reg[DATA_W-1];

endmodule

// File: tb/tb_spi_master_gen.sv
// Scoreboard bench for spi_master_gen: a behavioural SPI slave decodes mosi and drives miso,
// expectations are queued at each accepted go and checked when done pulses.
module tb_spi_master_gen;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 8-bit DUT signals
  logic         rst, go, ready, done, cpol, cpha, lsb_first, hold_cs, sclk, mosi, miso, cs_n;
  logic [7:0]   data_in, data_out, clk_div;
  // 16-bit DUT signals
  logic         rst16, go16, ready16, done16, sclk16, mosi16, miso16, cs_n16;
  logic [15:0]  data16, data_out16;
  logic [7:0]   clk_div16;

  spi_master_gen #(.DATA_W(8), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .go(go), .ready(ready), .done(done),
    .data_in(data_in), .data_out(data_out), .clk_div(clk_div),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .hold_cs(hold_cs),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master_gen #(.DATA_W(16), .DIV_W(8)) dut16 (
    .clk(clk), .rst(rst16), .go(go16), .ready(ready16), .done(done16),
    .data_in(data16), .data_out(data_out16), .clk_div(clk_div16),
    .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .hold_cs(1'b0),
    .sclk(sclk16), .mosi(mosi16), .miso(miso16), .cs_n(cs_n16)
  );

  typedef struct packed {
    logic [7:0]  exp_rx;
    logic [7:0]  exp_mosi;
    logic [31:0] exp_done;
    logic [31:0] exp_first;
    logic        hold;
    logic        pol;
  } exp_t;
  typedef struct packed {
    logic [15:0] exp_mosi;
    logic [31:0] exp_done;
  } exp16_t;

  exp_t   sb_q[$];
  exp16_t q16[$];

  logic       cs_held = 1'b0;
  logic [7:0] slave_word = 8'h00;
  logic       loopback = 1'b0;
  logic       miso_drv = 1'b0;
  assign miso = loopback ? mosi : miso_drv;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- slave model + monitor for the 8-bit DUT ----------------
  logic       active = 1'b0, b_pol, b_pha, b_lsb, prev_sclk, pend = 1'b0, lead;
  logic [7:0] b_word, mosi_word;
  int         acc_cyc, edges, samp_idx, first_edge, viol, n_xfer = 0, bi;
  exp_t       e;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      active = 1'b0;
      pend   = 1'b0;
    end else begin
      if (pend) begin
        if (samp_idx < W) begin
          bi = b_lsb ? samp_idx : W - 1 - samp_idx;
          miso_drv = b_word[bi[2:0]];
        end
        pend = 1'b0;
      end
      if (active) begin
        if (cyc > acc_cyc && !done && (cs_n || ready)) viol++;
        if (sclk !== prev_sclk) begin
          edges++;
          if (edges == 1) first_edge = cyc;
          lead = (prev_sclk == b_pol);
          if (lead ^ b_pha) begin
            if (samp_idx < W) begin
              bi = b_lsb ? samp_idx : W - 1 - samp_idx;
              mosi_word[bi[2:0]] = mosi;
            end
            samp_idx++;
            pend = 1'b1;
          end
          prev_sclk = sclk;
        end
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, want no transfer pending (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          n_xfer++;
          check("data_out", 32'(data_out), 32'(e.exp_rx));
          check("done_cycle", cyc, e.exp_done);
          check("first_edge_cycle", first_edge, e.exp_first);
          check("edge_count", edges, 2 * W);
          check("mosi_word", 32'(mosi_word), 32'(e.exp_mosi));
          check("cs_n_at_done", 32'(cs_n), 32'(!e.hold));
          check("busy_window_violations", viol, 0);
          check("sclk_idle_at_done", 32'(sclk), 32'(e.pol));
          $display("xfer %0d: mosi=%02h data_out=%02h done@%0d hold=%0b", n_xfer, mosi_word, data_out, cyc, e.hold);
        end
        active = 1'b0;
      end
      if (go && ready) begin
        active     = 1'b1;
        acc_cyc    = cyc;
        b_pol      = cpol;
        b_pha      = cpha;
        b_lsb      = lsb_first;
        b_word     = slave_word;
        prev_sclk  = cpol;
        edges      = 0;
        samp_idx   = 0;
        first_edge = -1;
        viol       = 0;
        mosi_word  = 8'h00;
        pend       = 1'b0;
        miso_drv   = lsb_first ? slave_word[0] : slave_word[7];
      end
    end
  end

  // ---------------- slave model + monitor for the 16-bit DUT (mode 0, MSB first) ----------------
  logic        act16 = 1'b0, prev16, pend16 = 1'b0;
  logic [15:0] word16 = 16'hBEEF, mosi16w;
  int          idx16, edges16, acc16;
  exp16_t      e16;

  initial forever begin
    @(negedge clk);
    if (rst16) begin
      act16  = 1'b0;
      pend16 = 1'b0;
    end else begin
      if (pend16) begin
        if (idx16 < 16) miso16 = word16[15 - idx16];
        pend16 = 1'b0;
      end
      if (act16 && sclk16 !== prev16) begin
        edges16++;
        if (sclk16 && idx16 < 16) begin
          mosi16w[15 - idx16] = mosi16;
          idx16++;
          pend16 = 1'b1;
        end
        prev16 = sclk16;
      end
      if (done16) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done16: got done=1, want no transfer pending (cycle %0d)", cyc);
        end else begin
          e16 = q16.pop_front();
          check("w16_data_out", 32'(data_out16), 32'h0000BEEF);
          check("w16_done_cycle", cyc, e16.exp_done);
          check("w16_edge_count", edges16, 32);
          check("w16_mosi_word", 32'(mosi16w), 32'(e16.exp_mosi));
          $display("xfer16: mosi=%04h data_out=%04h done@%0d", mosi16w, data_out16, cyc);
        end
        act16 = 1'b0;
      end
      if (go16 && ready16) begin
        act16   = 1'b1;
        acc16   = cyc;
        prev16  = 1'b0;
        edges16 = 0;
        idx16   = 0;
        mosi16w = 16'h0000;
        miso16  = word16[15];
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; holds go until accepted, then queues the expectation.
  task automatic start(input logic [7:0] d, input logic [7:0] w, input logic [7:0] dv,
                       input logic pol, input logic pha, input logic lsb, input logic hold,
                       input logic lb);
    int   h;
    bit   ok;
    exp_t x;
    data_in = d; slave_word = w; clk_div = dv; cpol = pol; cpha = pha;
    lsb_first = lsb; hold_cs = hold; loopback = lb; go = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      h = int'(dv) + 1;
      x.exp_rx    = lb ? d : w;
      x.exp_mosi  = d;
      x.hold      = hold;
      x.pol       = pol;
      x.exp_first = cyc + 1 + (cs_held ? 1 : 2) * h;
      x.exp_done  = cyc + 1 + (2 * W + (cs_held ? 1 : 2)) * h;
      sb_q.push_back(x);
      cs_held = hold;
    end else begin
      checks++;
      errors++;
      $display("FAIL go_accept_timeout: got ready=0 for 200 cycles, want ready=1");
    end
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 3000 cycles, want done pulse");
    end
  endtask

  task automatic run_main();
    logic [7:0] d, w, dv;
    logic       pol, pha, lsb, hold, cur_pol;
    // mode0, divide 0, loopback
    start(8'hA5, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done();
    // mode3, divide 2, slave returns C3
    start(8'h3C, 8'hC3, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done();
    // mode1, LSB first
    start(8'h01, 8'h80, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done();
    // back-to-back with chip select held across the word boundary
    start(8'h5A, 8'h96, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done();
    start(8'hE7, 8'h18, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done();
    // go while busy must be ignored
    start(8'h96, 8'h4B, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    go = 1'b1; data_in = 8'hFF; clk_div = 8'd0; cpha = 1'b1; lsb_first = 1'b1; hold_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1 go = 1'b0;
    wait_done();
    // reset in the middle of a transfer
    start(8'h69, 8'h33, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    sb_q.delete();
    cs_held = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    // randomized transfers
    cur_pol = 1'b0;
    for (int t = 0; t < 30; t++) begin
      d    = 8'($urandom);
      w    = 8'($urandom);
      dv   = 8'($urandom_range(0, 3));
      pol  = cs_held ? cur_pol : 1'($urandom_range(0, 1));
      pha  = 1'($urandom_range(0, 1));
      lsb  = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0);
      cur_pol = pol;
      start(d, w, dv, pol, pha, lsb, hold, 1'b0);
      wait_done();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic run_16();
    bit ok;
    exp16_t x;
    data16 = 16'($urandom);
    clk_div16 = 8'd255;
    go16 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready16) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      x.exp_mosi = data16;
      x.exp_done = cyc + 1 + (2 * 16 + 2) * 256;
      q16.push_back(x);
    end else begin
      checks++;
      errors++;
      $display("FAIL go16_accept_timeout: got ready=0, want ready=1");
    end
    @(posedge clk);
    #1 go16 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (done16) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done16_timeout: got no done in 10000 cycles, want done pulse");
    end
  endtask

  initial begin
    rst = 1'b1; rst16 = 1'b1;
    go = 1'b0; data_in = 8'h00; clk_div = 8'd0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; hold_cs = 1'b0;
    go16 = 1'b0; data16 = 16'h0000; clk_div16 = 8'd0; miso16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst16_ready", 32'(ready16), 32'd1);
    check("rst16_cs_n", 32'(cs_n16), 32'd1);
    check("rst16_data_out", 32'(data_out16), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; rst16 = 1'b0;
    fork
      run_main();
      run_16();
    join
    repeat (20) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("scoreboard16_drained", q16.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
